// File: rtl/stackcalc_param_if.sv
// Op request channel of the stack calculator: valid/ready handshake with opcode and operand.
interface stackcalc_param_if #(
   parameter int WIDTH = 8
);
   logic             op_valid;
   logic [2:0]       op;
   logic [WIDTH-1:0] op_data;
   logic             op_ready;

   modport master (
      output op_valid,
      output op,
      output op_data,
      input  op_ready
   );

   modport slave (
      input  op_valid,
      input  op,
      input  op_data,
      output op_ready
   );
endinterface

// File: rtl/stackcalc_param.sv
// Parameterised RPN stack calculator with a multiplexed hex 7-segment readout of top-of-stack.
// Define STACKCALC_MUL_EN to enable opcode 110 (MUL); otherwise it is treated as an illegal op.
module stackcalc_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int MAX_COUNT = 10000000
) (
   input  logic              clk,
   input  logic              rst,
   stackcalc_param_if.slave  bus,
   output logic [WIDTH-1:0]  top,
   output logic [6:0]        count,
   output logic              full,
   output logic              empty,
   output logic              err,
   output logic [6:0]        segments,
   output logic [1:0]        digit
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(MAX_COUNT - 1);
   localparam logic [1:0]    DIGIT_LAST = 2'(WIDTH / 4 - 1);
   localparam logic [6:0]    SEG_DASH   = 7'b1000000;
   localparam logic [6:0]    SEG_ERR    = 7'b1111001;

   typedef enum logic [2:0] {
      OP_PUSH = 3'b000,
      OP_POP  = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_DUP  = 3'b100,
      OP_SWAP = 3'b101,
      OP_MUL  = 3'b110,
      OP_CLR  = 3'b111
   } op_e;

   typedef enum logic {
      ST_RUN,
      ST_STALL
   } state_e;

   state_e state, state_next;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [6:0]       count_q, count_next;
   logic             err_q, err_next;
   logic [PW-1:0]    presc;
   logic [1:0]       digit_q;

   op_e              opc;
   logic             ready;
   logic             accept;
   logic             set_err;
   logic             binop;
   logic             has1, has2, is_full;
   logic [AW-1:0]    ptr_free, ptr_t, ptr_n;
   logic [WIDTH-1:0] val_t, val_n, alu;

   logic             we_a, we_b;
   logic [AW-1:0]    addr_a, addr_b;
   logic [WIDTH-1:0] data_a, data_b;

   logic [3:0]       nibble;
   logic [6:0]       glyph;

   assign opc    = op_e'(bus.op);
   assign ready  = (state == ST_RUN);
   assign accept = bus.op_valid && ready;
   assign bus.op_ready = ready;

   // Pointers wrap modulo 2^AW, which is harmless: count alone decides which entries are live.
   assign ptr_free = count_q[AW-1:0];
   assign ptr_t    = ptr_free - AW'(1);
   assign ptr_n    = ptr_free - AW'(2);
   assign val_t    = mem[ptr_t];
   assign val_n    = mem[ptr_n];

   assign has1    = (count_q != 7'd0);
   assign has2    = (count_q > 7'd1);
   assign is_full = (count_q == 7'(DEPTH));

   // Binary ops all consume T and N and write the result into N's slot.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      alu   = val_n + val_t;
      binop = 1'b0;
      case (opc)
         OP_ADD: binop = 1'b1;
         OP_SUB: begin
            alu   = val_n - val_t;
            binop = 1'b1;
         end
`ifdef STACKCALC_MUL_EN
         OP_MUL: begin
            alu   = WIDTH'(val_n * val_t);
            binop = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      count_next = count_q;
      err_next   = err_q;
      set_err    = 1'b0;
      we_a       = 1'b0;
      we_b       = 1'b0;
      addr_a     = ptr_free;
      addr_b     = ptr_n;
      data_a     = bus.op_data;
      data_b     = val_t;
      if (accept) begin
         if (binop) begin
            if (!has2) begin
               set_err = 1'b1;
            end else begin
               we_a       = 1'b1;
               addr_a     = ptr_n;
               data_a     = alu;
               count_next = count_q - 7'd1;
            end
         end else begin
            case (opc)
               OP_PUSH: begin
                  if (is_full) begin
                     set_err = 1'b1;
                  end else begin
                     we_a       = 1'b1;
                     count_next = count_q + 7'd1;
                  end
               end
               OP_POP: begin
                  if (!has1) set_err = 1'b1;
                  else       count_next = count_q - 7'd1;
               end
               OP_DUP: begin
                  if (!has1 || is_full) begin
                     set_err = 1'b1;
                  end else begin
                     we_a       = 1'b1;
                     data_a     = val_t;
                     count_next = count_q + 7'd1;
                  end
               end
               OP_SWAP: begin
                  if (!has2) begin
                     set_err = 1'b1;
                  end else begin
                     we_a   = 1'b1;
                     addr_a = ptr_t;
                     data_a = val_n;
                     we_b   = 1'b1;
                     addr_b = ptr_n;
                     data_b = val_t;
                  end
               end
               OP_CLR:  count_next = 7'd0;
               default: set_err = 1'b1;
            endcase
         end
         err_next = (opc == OP_CLR) ? 1'b0 : (err_q | set_err);
      end
   end

   // A faulting op costs one dead cycle on the request channel.
   always_comb begin
      state_next = ST_RUN;
      if (accept && set_err) state_next = ST_STALL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state is written with non-blocking assignments so all registers update together.
         state   <= ST_RUN;
         count_q <= 7'd0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_next;
         count_q <= count_next;
         err_q   <= err_next;
      end
   end

   // NOTE: stack storage has no reset; entries above count are invisible, so clearing them buys nothing.
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= data_a;
      if (we_b) mem[addr_b] <= data_b;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc   <= '0;
         digit_q <= 2'd0;
      end else if (presc == PRESC_LAST) begin
         presc   <= '0;
         digit_q <= (digit_q == DIGIT_LAST) ? 2'd0 : digit_q + 2'd1;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'b0111111;
         4'h1: hex_glyph = 7'b0000110;
         4'h2: hex_glyph = 7'b1011011;
         4'h3: hex_glyph = 7'b1001111;
         4'h4: hex_glyph = 7'b1100110;
         4'h5: hex_glyph = 7'b1101101;
         4'h6: hex_glyph = 7'b1111101;
         4'h7: hex_glyph = 7'b0000111;
         4'h8: hex_glyph = 7'b1111111;
         4'h9: hex_glyph = 7'b1101111;
         4'hA: hex_glyph = 7'b1110111;
         4'hB: hex_glyph = 7'b1111100;
         4'hC: hex_glyph = 7'b0111001;
         4'hD: hex_glyph = 7'b1011110;
         4'hE: hex_glyph = 7'b1111001;
         default: hex_glyph = 7'b1110001;
      endcase
   endfunction

   assign top    = has1 ? val_t : '0;
   assign nibble = 4'(top >> {digit_q, 2'b00});
   assign glyph  = hex_glyph(nibble);

   always_comb begin
      segments = glyph;
      if (err_q)      segments = SEG_ERR;
      else if (!has1) segments = SEG_DASH;
   end

   assign count = count_q;
   assign full  = is_full;
   assign empty = !has1;
   assign err   = err_q;
   assign digit = digit_q;

endmodule

// File: tb/tb_stackcalc_param.sv
// Scoreboard bench for stackcalc_param: a queue-based stack model predicts each accepted op,
// a monitor compares results and the multiplexed display every cycle.
`timescale 1ns/1ps
module tb_stackcalc_param;
   localparam int WIDTH     = 8;
   localparam int DEPTH     = 4;
   localparam int MAX_COUNT = 4;
   localparam int NDIG      = WIDTH / 4;
   localparam int MASK      = (1 << WIDTH) - 1;

   localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3,
                          DUP  = 3'd4, SWAP = 3'd5, MUL = 3'd6, CLR = 3'd7;

   localparam logic [6:0] GLYPH [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] top;
   logic [6:0]       count;
   logic             full, empty, err;
   logic [6:0]       segments;
   logic [1:0]       digit;

   stackcalc_param_if #(.WIDTH(WIDTH)) bus ();

   stackcalc_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_COUNT(MAX_COUNT)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .top      (top),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .err      (err),
      .segments (segments),
      .digit    (digit)
   );

   always #5 clk = ~clk;

   typedef struct {
      int top;
      int count;
      bit err;
      bit ready;
   } exp_t;

   exp_t exp_q [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference model: the stack is a plain queue, last element is top.
   int stk [$];
   bit m_err   = 1'b0;
   bit m_ready = 1'b1;

   function automatic bit model_apply(input logic [2:0] opc, input int data);
      int t, n;
      bit bad = 1'b0;
      case (opc)
         PUSH: if (stk.size() == DEPTH) bad = 1; else stk.push_back(data & MASK);
         POP:  if (stk.size() < 1) bad = 1; else void'(stk.pop_back());
         ADD, SUB, MUL: begin
`ifndef STACKCALC_MUL_EN
            if (opc == MUL) bad = 1; else
`endif
            if (stk.size() < 2) bad = 1;
            else begin
               t = stk.pop_back();
               n = stk.pop_back();
               if (opc == ADD)      stk.push_back((n + t) & MASK);
               else if (opc == SUB) stk.push_back((n - t) & MASK);
               else                 stk.push_back((n * t) & MASK);
            end
         end
         DUP:  if (stk.size() < 1 || stk.size() == DEPTH) bad = 1; else stk.push_back(stk[$]);
         SWAP: if (stk.size() < 2) bad = 1;
               else begin
                  t = stk.pop_back();
                  n = stk.pop_back();
                  stk.push_back(t);
                  stk.push_back(n);
               end
         default: begin
            stk.delete();
            m_err = 0;
         end
      endcase
      if (bad) m_err = 1;
      return bad;
   endfunction

   task automatic drive_now(input bit v, input logic [2:0] opc, input logic [WIDTH-1:0] d);
      bit   bad;
      exp_t e;
      bus.op_valid = v;
      bus.op       = opc;
      bus.op_data  = d;
      if (v && m_ready) begin
         bad     = model_apply(opc, int'(d));
         e.top   = (stk.size() > 0) ? stk[$] : 0;
         e.count = stk.size();
         e.err   = m_err;
         e.ready = !bad;
         exp_q.push_back(e);
         m_ready = !bad;
      end else begin
         m_ready = 1'b1;
      end
   endtask

   task automatic drive(input bit v, input logic [2:0] opc, input logic [WIDTH-1:0] d);
      @(negedge clk);
      drive_now(v, opc, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, PUSH, '0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_top"},      top,          0);
      check({tag, "_count"},    count,        0);
      check({tag, "_err"},      err,          0);
      check({tag, "_full"},     full,         0);
      check({tag, "_empty"},    empty,        1);
      check({tag, "_op_ready"}, bus.op_ready, 1);
      check({tag, "_segments"}, segments,     7'b1000000);
      check({tag, "_digit"},    digit,        0);
   endtask

   // Async reset lands between edges; the op presented while reset releases must be accepted.
   task automatic reset_mid();
      drive(1'b0, PUSH, '0);
      @(posedge clk);
      #3 rst = 1'b0;
      #1 check_reset_values("rst_mid");
      stk.delete();
      m_err   = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      drive_now(1'b1, PUSH, WIDTH'($urandom));
      #2 rst = 1'b1;
   endtask

   // Monitor: handshake sampled at the edge, results and display compared on the falling edge.
   bit         acc = 1'b0;
   int         cyc = 0;
   int         cur_top = 0, cur_cnt = 0;
   bit         cur_err = 1'b0;
   bit         exp_rdy;
   int         exp_dig;
   exp_t       got;
   logic [6:0] exp_seg;

   always @(posedge clk) begin
      acc = rst && bus.op_valid && bus.op_ready;
      if (rst) cyc++;
   end

   always @(negedge clk) begin
      if (!rst) begin
         cur_top = 0;
         cur_cnt = 0;
         cur_err = 1'b0;
         cyc     = 0;
      end else begin
         exp_rdy = 1'b1;
         if (acc) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL accept: DUT accepted an op the model did not expect at %0t", $time);
            end else begin
               got = exp_q.pop_front();
               check("top",   top,   got.top);
               check("count", count, got.count);
               check("err",   err,   got.err);
               check("full",  full,  got.count == DEPTH);
               check("empty", empty, got.count == 0);
               cur_top = got.top;
               cur_cnt = got.count;
               cur_err = got.err;
               exp_rdy = got.ready;
            end
         end
         check("op_ready", bus.op_ready, exp_rdy);
         exp_dig = (cyc / MAX_COUNT) % NDIG;
         check("digit", digit, exp_dig);
         if (cur_err)           exp_seg = 7'b1111001;
         else if (cur_cnt == 0) exp_seg = 7'b1000000;
         else                   exp_seg = GLYPH[(cur_top >> (4 * exp_dig)) & 15];
         check("segments", segments, exp_seg);
      end
   end

   initial begin
      bus.op_valid = 1'b0;
      bus.op       = PUSH;
      bus.op_data  = '0;
      #3 check_reset_values("rst_init");
      @(negedge clk);
      #2 rst = 1'b1;

      // Subtract ordering and the single-element result.
      drive(1, PUSH, 8'h12); drive(1, PUSH, 8'h05); drive(1, SUB, 8'h00);
      idle(1); drive(1, CLR, 8'h00);

      // Wrapping add, then MUL (result or illegal-op stall depending on the build).
      drive(1, PUSH, 8'hF0); drive(1, PUSH, 8'h20); drive(1, ADD, 8'h00);
      drive(1, PUSH, 8'h11); drive(1, MUL, 8'h00); idle(2); drive(1, CLR, 8'h00);

      // Overflow on the fifth push, then CLR recovers.
      for (int i = 1; i <= 5; i++) drive(1, PUSH, WIDTH'(i));
      idle(1); drive(1, CLR, 8'h00); idle(1);

      // Underflow, request held through the stall, then a legal push with err still set.
      drive(1, POP, 8'h00); drive(1, PUSH, 8'h07); drive(1, PUSH, 8'h07);
      drive(1, DUP, 8'h00); drive(1, SWAP, 8'h00); idle(1);
      drive(1, CLR, 8'h00);

      // Display scan: hold one value long enough to see both nibbles and the wrap.
      drive(1, PUSH, 8'hA3); idle(3 * MAX_COUNT * NDIG); drive(1, CLR, 8'h00);

      reset_mid();

      for (int i = 0; i < 1500; i++) begin
         int r;
         logic [2:0] opc;
         r   = $urandom_range(0, 11);
         opc = (r < 4 || r == 11) ? PUSH : 3'(r - 3);
         drive($urandom_range(0, 9) < 7, opc, WIDTH'($urandom));
         if (i == 700) reset_mid();
      end

      idle(3);
      check("drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/stackcalc_param.md
STACKCALC_PARAM -- requirements
Module: stackcalc_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data/stack word width; legal values 4, 8, 12, 16.
REQ-002 SHALL have parameter DEPTH, default 8: stack entries, 2..64.
REQ-003 SHALL have parameter MAX_COUNT, default 10000000: clock cycles per display digit step, >=2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port op_valid  input  1  op request.
REQ-007 SHALL have port op  input  3  opcode.
REQ-008 SHALL have port op_data  input  WIDTH  PUSH operand.
REQ-009 SHALL have port op_ready  output  1  op accepted when op_valid and op_ready both high at a clk edge.
REQ-010 SHALL have port top  output  WIDTH  top-of-stack value, 0 when empty.
REQ-011 SHALL have port count  output  7  number of occupied entries.
REQ-012 SHALL have ports full, empty, err  output  1 each  count==DEPTH, count==0, sticky error.
REQ-013 SHALL have port segments  output  7  active-high {g,f,e,d,c,b,a}.
REQ-014 SHALL have port digit  output  2  index of the nibble of top currently shown (0 = least significant).

Function
REQ-015 Opcodes SHALL be: 000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 DUP, 101 SWAP, 110 MUL (see Configuration), 111 CLR.
REQ-016 Each accepted op SHALL complete in one cycle; top/count/flags SHALL reflect it on the following clk edge.
REQ-017 op_ready SHALL be high at all times out of reset except the single cycle following an accepted op that set err (error stall).
REQ-018 PUSH SHALL place op_data on top, count+1; POP SHALL drop top, count-1.
REQ-019 ADD/SUB/MUL SHALL consume top (T) and next (N) and push one result: N+T, N-T, N*T, each truncated modulo 2^WIDTH; count-1.
REQ-020 DUP SHALL push a copy of T; SWAP SHALL exchange T and N; CLR SHALL set count=0 and clear err.
REQ-021 Underflow (POP/DUP with count<1; ADD/SUB/MUL/SWAP with count<2) SHALL leave stack unchanged and set err.
REQ-022 Overflow (PUSH/DUP when full) SHALL leave stack unchanged and set err.
REQ-023 err SHALL remain set until CLR or reset; further legal ops SHALL still execute while err is set.
REQ-024 A prescaler SHALL count 0..MAX_COUNT-1; on wrap, digit SHALL advance 0..(WIDTH/4)-1 and wrap to 0.
REQ-025 segments SHALL show hex glyph of nibble[digit] of top (standard 0-9, A, b, C, d, E, F) when not empty.
REQ-026 When empty, segments SHALL be 7'b1000000 (dash); when err set, segments SHALL be 7'b1111001 (E), overriding both.
REQ-027 Display SHALL update combinationally from registered top/digit/err; no op SHALL reset prescaler or digit.

Reset
REQ-028 rst low SHALL immediately force count=0, err=0, top=0, prescaler=0, digit=0, op_ready=1, empty=1, full=0, segments=7'b1000000.
REQ-029 An op presented in the cycle rst deasserts SHALL be accepted normally; reset mid-operation SHALL discard all stack contents.
REQ-030 Stack storage contents need not be cleared; only count governs visibility.

Configuration
REQ-031 Macro STACKCALC_MUL_EN defined: opcode 110 SHALL perform MUL per REQ-019.
REQ-032 Macro STACKCALC_MUL_EN undefined: opcode 110 SHALL be illegal, leave stack unchanged, set err; no multiplier SHALL be synthesised.

Verification (WIDTH=8, DEPTH=4, MAX_COUNT=4)
REQ-033 PUSH 0x12, PUSH 0x05, SUB -> top=0x0D, count=1, err=0.
REQ-034 PUSH 0xF0, PUSH 0x20, ADD -> top=0x10 (wrap), count=1; MUL with STACKCALC_MUL_EN on 0x10,0x11 -> top=0x10; without macro -> err=1, count=2, op_ready low one cycle.
REQ-035 Five PUSHes (1..5) -> full=1 after fourth, fifth sets err, top=0x04, count=4; CLR -> count=0, err=0, segments=dash.
REQ-036 POP on empty -> err=1, segments=7'b1111001, next PUSH 0x07 executes (count=1) with err still 1.
REQ-037 PUSH 0xA3, hold idle -> digit 0 for 4 cycles showing "3" (7'b1001111), then digit 1 showing "A" (7'b1110111), then back to 0.
REQ-038 Assert rst low mid-sequence asynchronously between edges -> all outputs reach REQ-028 values before next clk edge.
